granule_reader: RTL
===================

Name: granule_reader

Overview:
- Downstream consumer of the two-channel granule double buffer.
- Waits for the upstream decoder to declare a granule complete, then issues the buffer switch so the freshly written bank becomes readable.
- Walks addresses 0..SAMPLES_PER_GRANULE-1 on both channels in lockstep and presents each stereo pair on a valid/ready stream to the audio output stage.
- Flags underrun (no granule ready when the current one ends) and overrun (a granule completed while another was still pending).

Parameters:
- DATA_WIDTH, 18, sample width per channel
- ADDR_BITS, 10, granule buffer address width
- SAMPLES_PER_GRANULE, 576, samples per channel per granule; must be ≤ 2^ADDR_BITS
- RD_LATENCY, 1, cycles from read address to valid read data (1 or 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- granule_ready  in  1  one-cycle pulse from upstream: write bank holds a complete granule
- buffer_switch_event  out  1  one-cycle pulse to the granule buffer: swap read/write banks
- ch0_read_addr  out  ADDR_BITS  channel 0 read address
- ch0_read_data  in  DATA_WIDTH  channel 0 read data, RD_LATENCY after address
- ch1_read_addr  out  ADDR_BITS  channel 1 read address, always equal to ch0_read_addr
- ch1_read_data  in  DATA_WIDTH  channel 1 read data
- sample_valid  out  1  stereo sample available
- sample_ready  in  1  consumer accepts sample
- sample_left  out  DATA_WIDTH  channel 0 sample
- sample_right  out  DATA_WIDTH  channel 1 sample
- underrun  out  1  one-cycle pulse: granule finished, none pending
- overrun  out  1  one-cycle pulse: granule_ready while already pending and not consumed this cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; pending=0; addr=0; all outputs 0.
- pending flag: next = granule_ready | (pending & ~buffer_switch_event). A granule_ready coinciding with a switch leaves pending=1.
- overrun = granule_ready & pending & ~buffer_switch_event, registered, so it appears one cycle later.
- FSM states:
  - IDLE: addr=0. If pending, go to SWITCH.
  - SWITCH: buffer_switch_event=1 for exactly this cycle; go to SETTLE.
  - SETTLE: one cycle so the bank select in the buffer takes effect; addr=0 is driven; go to FETCH.
  - FETCH: address held stable for RD_LATENCY cycles, counted with a latency counter. On the last cycle, register ch0/ch1 read data into sample_left/right, set sample_valid=1 and go to HOLD.
  - HOLD: sample_valid=1; data and address stable until sample_ready=1.
    - On transfer with addr < SAMPLES_PER_GRANULE-1: addr+1, sample_valid=0, go to FETCH.
    - On transfer with addr = SAMPLES_PER_GRANULE-1: sample_valid=0, go to END.
  - END: if pending, go to SWITCH (next granule, no IDLE detour). Otherwise pulse underrun for one cycle, go to IDLE.
- Handshake rules:
  - sample_valid never drops without a transfer.
  - sample_ready is ignored while sample_valid=0.
  - Throughput is one sample per RD_LATENCY+1 cycles at sample_ready=1. This is ample for audio rates.
- Address arithmetic: unsigned ADDR_BITS counter; never exceeds SAMPLES_PER_GRANULE-1; no wrap.
- granule_ready in any state only updates pending; it never restarts a granule in progress.
- Reset mid-granule: immediate return to the reset state; pending is lost; no switch pulse is emitted.

Decomposition:
- Shared include/package granule_defs: FSM state encodings (IDLE, SWITCH, SETTLE, FETCH, HOLD, END), SAMPLES_PER_GRANULE default 576, granule DATA_WIDTH 18, ADDR_BITS 10. The decoder write side and this block both use it.
- No sub-module; FSM, latency counter and pending flag stay in one module of about 180 lines.

Test Plan:
- Reset then granule_ready pulse at cycle 5 → buffer_switch_event pulse at cycle 7; first sample_valid with addr 0 data (RAM preloaded L=addr, R=addr+0x100) → sample_left=0, sample_right=0x100.
- sample_ready held 1, RD_LATENCY=1 → 576 samples at 2-cycle spacing, values 0..575 / 0x100..0x33F in order; last transfer followed by underrun pulse; busy=0 afterwards.
- Random sample_ready (30% duty) → sample_left/right and addresses stable across every stalled cycle; no sample lost or duplicated over 576 samples.
- Second granule_ready issued mid-granule → after sample 575, END→SWITCH directly; no underrun; new bank data (L=0x2000+addr) streamed.
- Two granule_ready pulses within one granule → overrun pulse one cycle after the second; pending stays 1; exactly one switch at granule end.
- rst asserted while in HOLD at addr 300 → all outputs 0 asynchronously; after release and a new granule_ready, streaming restarts at addr 0.

Source files
------------

// File: rtl/granule_reader_pkg.sv
// granule_reader_pkg
//   Shared definitions for the two-channel granule double buffer. The decoder
//   write side and the granule reader both import this package so that the
//   default granule geometry and the reader state encoding live in one place.
//
//   Contents:
//     GR_DATA_WIDTH          default sample width per channel
//     GR_ADDR_BITS           default granule buffer address width
//     GR_SAMPLES_PER_GRANULE default samples per channel per granule
//     GR_RD_LATENCY          default buffer read latency (1 or 2)
//     gr_state_e             reader FSM state encoding
//     gr_pending_next()      next value of the "granule pending" flag
//     gr_overrun()           overrun condition for the current cycle
package granule_reader_pkg;

  localparam int unsigned GR_DATA_WIDTH          = 18;
  localparam int unsigned GR_ADDR_BITS           = 10;
  localparam int unsigned GR_SAMPLES_PER_GRANULE = 576;
  localparam int unsigned GR_RD_LATENCY          = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWITCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FETCH  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_END    = 3'd5
  } gr_state_e;

  // A fresh granule_ready always wins over a same-cycle bank switch, so a
  // granule announced exactly while the previous one is being switched in is
  // not lost.
  function automatic logic gr_pending_next(input logic granule_ready,
                                           input logic pending,
                                           input logic switch_event);
    return granule_ready | (pending & ~switch_event);
  endfunction

  // A granule completed while another is still waiting and not being taken
  // this cycle overwrites the waiting one.
  function automatic logic gr_overrun(input logic granule_ready,
                                      input logic pending,
                                      input logic switch_event);
    return granule_ready & pending & ~switch_event;
  endfunction

endpackage

// File: rtl/granule_reader.sv
// granule_reader
//   Downstream consumer of the two-channel granule double buffer. Waits for
//   the decoder to announce a complete granule, pulses the buffer switch so
//   the freshly written bank becomes readable, then walks addresses
//   0..SAMPLES_PER_GRANULE-1 on both channels in lockstep and presents each
//   stereo pair on a valid/ready stream. Flags underrun (granule finished with
//   nothing pending) and overrun (granule announced while one was pending).
//
//   Read data is expected valid in the RD_LATENCY-th cycle that an address is
//   held on ch*_read_addr; the FETCH state holds the address for exactly that
//   many cycles before capturing.
//
//   Ports:
//     clk                  system clock, rising edge
//     rst                  asynchronous reset, active low
//     granule_ready        1-cycle pulse: write bank holds a complete granule
//     buffer_switch_event  1-cycle pulse to the buffer: swap read/write banks
//     ch0_read_addr        channel 0 read address
//     ch0_read_data        channel 0 read data
//     ch1_read_addr        channel 1 read address (always equals ch0)
//     ch1_read_data        channel 1 read data
//     sample_valid         stereo sample available
//     sample_ready         consumer accepts sample
//     sample_left          channel 0 sample
//     sample_right         channel 1 sample
//     underrun             1-cycle pulse: granule finished, none pending
//     overrun              1-cycle pulse: granule_ready while already pending
//     busy                 high in every state except IDLE
module granule_reader
  import granule_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = GR_DATA_WIDTH,
  parameter int unsigned ADDR_BITS           = GR_ADDR_BITS,
  parameter int unsigned SAMPLES_PER_GRANULE = GR_SAMPLES_PER_GRANULE,
  parameter int unsigned RD_LATENCY          = GR_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  granule_ready,
  output logic                  buffer_switch_event,
  output logic [ADDR_BITS-1:0]  ch0_read_addr,
  input  logic [DATA_WIDTH-1:0] ch0_read_data,
  output logic [ADDR_BITS-1:0]  ch1_read_addr,
  input  logic [DATA_WIDTH-1:0] ch1_read_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SAMPLES_PER_GRANULE - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  // Latency counter only ever needs to reach RD_LATENCY-1 (0 or 1).
  localparam logic [1:0]           LAT_LAST  = 2'(RD_LATENCY - 1);

  gr_state_e             state_q;
  logic                  pending_q;
  logic                  pending_d;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  switch_q;
  logic                  underrun_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [1:0]            lat_q;
  logic [DATA_WIDTH-1:0] left_q;
  logic [DATA_WIDTH-1:0] right_q;

  // Next value of the pending flag and the overrun condition.
  always_comb begin
    pending_d = gr_pending_next(granule_ready, pending_q, switch_q);
    overrun_d = gr_overrun(granule_ready, pending_q, switch_q);
  end

  // Reader FSM with latency counter, pending flag and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      switch_q   <= 1'b0;
      underrun_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      lat_q      <= 2'd0;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      // Single-cycle pulses fall back low unless a state re-asserts them.
      switch_q   <= 1'b0;
      underrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          addr_q <= '0;
          if (pending_q) begin
            state_q  <= ST_SWITCH;
            switch_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            busy_q   <= 1'b0;
          end
        end

        ST_SWITCH: begin
          state_q <= ST_SETTLE;
        end

        // The buffer's bank select updates on the switch edge; give it a
        // full cycle with address 0 before the first fetch.
        ST_SETTLE: begin
          addr_q  <= '0;
          lat_q   <= 2'd0;
          state_q <= ST_FETCH;
        end

        ST_FETCH: begin
          if (lat_q == LAT_LAST) begin
            left_q  <= ch0_read_data;
            right_q <= ch1_read_data;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            lat_q   <= lat_q + 2'd1;
          end
        end

        // Data and address frozen until the consumer takes the sample.
        ST_HOLD: begin
          if (sample_ready) begin
            valid_q <= 1'b0;
            lat_q   <= 2'd0;
            if (addr_q == LAST_ADDR) begin
              state_q <= ST_END;
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              state_q <= ST_FETCH;
            end
          end else begin
            state_q <= ST_HOLD;
          end
        end

        // Chain straight into the next granule when one is waiting.
        ST_END: begin
          if (pending_q) begin
            state_q  <= ST_SWITCH;
            switch_q <= 1'b1;
          end else begin
            underrun_q <= 1'b1;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            state_q    <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          lat_q   <= 2'd0;
        end
      endcase
    end
  end

  assign buffer_switch_event = switch_q;
  assign ch0_read_addr       = addr_q;
  assign ch1_read_addr       = addr_q;
  assign sample_valid        = valid_q;
  assign sample_left         = left_q;
  assign sample_right        = right_q;
  assign underrun            = underrun_q;
  assign overrun             = overrun_q;
  assign busy                = busy_q;

endmodule
